// File: rtl/plic_gateway_pkg.sv
// Shared types and helpers for the PLIC interrupt gateway: per-source state
// encoding and the claim/complete ID width.
package plic_gateway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_BUSY = 2'd2
  } gw_state_e;

  // ID 0 is reserved for "no source", so n sources need IDs 0..n.
  function automatic int unsigned id_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/plic_gw_src.sv
// One interrupt source: input synchroniser, rise detect, 1-deep edge latch
// with sticky drop flag, and the IDLE/PEND/BUSY gateway state machine.
module plic_gw_src
  import plic_gateway_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic en,
  input  logic edge_mode,
  input  logic claim,
  input  logic cmpl,
  output logic pend,
  output logic busy,
  output logic drop
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   p;
  logic                   rise;
  gw_state_e              state;
  gw_state_e              state_nxt;
  logic                   latch;
  logic                   latch_nxt;
  logic                   drop_q;
  logic                   drop_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      p    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], irq};
      p    <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      latch  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      latch  <= latch_nxt;
      drop_q <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    latch_nxt = latch;
    drop_nxt  = drop_q;
    unique case (state)
      ST_IDLE: begin
        if (en && (edge_mode ? rise : s)) state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          latch_nxt = 1'b0;
        end else begin
          if (claim) state_nxt = ST_BUSY;
          if (edge_mode && rise) begin
            if (latch) drop_nxt  = 1'b1;
            else       latch_nxt = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cmpl) begin
          // A rise coinciding with completion counts as already latched,
          // so it is never stranded in IDLE; if both exist, one stays latched.
          if (en && (edge_mode ? (latch | rise) : s)) begin
            state_nxt = ST_PEND;
            latch_nxt = edge_mode & latch & rise;
          end else begin
            state_nxt = ST_IDLE;
            latch_nxt = 1'b0;
          end
        end else if (edge_mode && rise) begin
          if (latch) drop_nxt  = 1'b1;
          else       latch_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        latch_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    pend = (state == ST_PEND);
    busy = (state == ST_BUSY);
    drop = drop_q;
  end

endmodule

// File: rtl/plic_irq_gateway.sv
// PLIC interrupt gateway: NUM_IRQ independent sources sharing one claim and
// one completion port; the ID decode to per-source strobes lives here.
module plic_irq_gateway
  import plic_gateway_pkg::*;
#(
  parameter  int unsigned NUM_IRQ     = 48,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned ID_W        = id_width(NUM_IRQ)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic [NUM_IRQ-1:0] irq_edge_i,
  input  logic               claim_vld_i,
  input  logic [ID_W-1:0]    claim_id_i,
  input  logic               cmpl_vld_i,
  input  logic [ID_W-1:0]    cmpl_id_i,
  output logic [NUM_IRQ-1:0] irq_pend_o,
  output logic [NUM_IRQ-1:0] irq_busy_o,
  output logic [NUM_IRQ-1:0] edge_drop_o
);

  logic [NUM_IRQ-1:0] claim_hit;
  logic [NUM_IRQ-1:0] cmpl_hit;

  // IDs 0 and >NUM_IRQ match no source, so they fall out of the decode.
  always_comb begin
    claim_hit = '0;
    cmpl_hit  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      claim_hit[i] = claim_vld_i && (claim_id_i == ID_W'(i + 1));
      cmpl_hit[i]  = cmpl_vld_i  && (cmpl_id_i  == ID_W'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : gen_src
    plic_gw_src #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_src (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .irq       (irq_i[g]),
      .en        (irq_en_i[g]),
      .edge_mode (irq_edge_i[g]),
      .claim     (claim_hit[g]),
      .cmpl      (cmpl_hit[g]),
      .pend      (irq_pend_o[g]),
      .busy      (irq_busy_o[g]),
      .drop      (edge_drop_o[g])
    );
  end

endmodule

// File: doc/plic_irq_gateway.md
PLIC_IRQ_GATEWAY -- requirements
Module: plic_irq_gateway

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 48: number of interrupt sources; source i carries ID i+1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per source; legal range 2..4.
REQ-003 SHALL derive localparam ID_W = $clog2(NUM_IRQ+1); ID 0 is reserved and means no source.
REQ-004 SHALL have port clk_i, input, 1: single clock.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port irq_i, input, NUM_IRQ: asynchronous interrupt lines.
REQ-007 SHALL have port irq_en_i, input, NUM_IRQ: per-source enable.
REQ-008 SHALL have port irq_edge_i, input, NUM_IRQ: per-source mode, 1 = rising-edge, 0 = level-high.
REQ-009 SHALL have port claim_vld_i, input, 1: claim strobe.
REQ-010 SHALL have port claim_id_i, input, ID_W: claimed ID.
REQ-011 SHALL have port cmpl_vld_i, input, 1: completion strobe.
REQ-012 SHALL have port cmpl_id_i, input, ID_W: completed ID.
REQ-013 SHALL have port irq_pend_o, output, NUM_IRQ: pending per source.
REQ-014 SHALL have port irq_busy_o, output, NUM_IRQ: claimed, awaiting completion.
REQ-015 SHALL have port edge_drop_o, output, NUM_IRQ: sticky flag, set when an edge is lost.

Function
REQ-016 SHALL pass each irq_i bit through SYNC_STAGES flops; synced value s[i] lags irq_i by SYNC_STAGES cycles.
REQ-017 SHALL register s[i] as p[i] and compute rise[i] = s[i] & ~p[i].
REQ-018 SHALL run a per-source FSM with states IDLE, PEND, BUSY; outputs irq_pend_o = (state==PEND) and irq_busy_o = (state==BUSY), both registered.
REQ-019 SHALL transition IDLE->PEND when en & (level ? s : rise); pending is visible SYNC_STAGES+1 cycles after an irq_i change.
REQ-020 SHALL transition PEND->BUSY when claim_vld_i & claim_id_i==i+1.
REQ-021 SHALL transition PEND->IDLE when en is low, and clear the edge latch.
REQ-022 SHALL hold BUSY regardless of irq_i or en changes until cmpl_vld_i & cmpl_id_i==i+1.
REQ-023 SHALL, in edge mode, latch one rise that occurs in BUSY or PEND (edge latch, 1 deep); a further rise while the latch is set sets edge_drop_o[i].
REQ-024 SHALL, on completion, go BUSY->PEND if en & (level ? s : latch); otherwise go BUSY->IDLE. The transition to PEND consumes the latch.
REQ-025 SHALL ignore a claim to a source not in PEND and a completion to a source not in BUSY.
REQ-026 SHALL ignore claim/complete IDs of 0 or greater than NUM_IRQ.
REQ-027 SHALL apply simultaneous claim and completion to different IDs in the same cycle.
REQ-028 SHALL, for the same ID in the same cycle, take only the transition legal from the current state.
REQ-029 SHALL sample the irq_edge_i change at the next IDLE evaluation; state is never aborted by a mode change.
REQ-030 SHALL clear edge_drop_o[i] only by reset.

Reset
REQ-031 SHALL, on rst_n_i low, asynchronously clear all sync flops, p, edge latches, and edge_drop_o, and force all FSMs to IDLE (irq_pend_o = irq_busy_o = 0).
REQ-032 SHALL, when reset asserts mid-claim, drop all BUSY ownership; reset deassertion SHALL be synchronous to clk_i by the integrator.

Structure
REQ-033 SHALL place the state enum (IDLE/PEND/BUSY, 2 bits) and an ID-width function in package plic_gateway_pkg.
REQ-034 SHALL implement one source (synchroniser, edge detect, latch, FSM) as sub-module plic_gw_src, generated NUM_IRQ times; the ID decode lives in the top level.

Verification
REQ-035 SHALL cover level mode: irq_i[3]=1, en=1 -> irq_pend_o[3]=1 at cycle 3; claim ID 4 -> busy; complete with line still high -> pend again the next cycle.
REQ-036 SHALL cover edge mode: pulse irq_i[0] 5 cycles, claim ID 1, two more pulses while busy -> edge_drop_o[0]=1; complete -> pend=1 once; second claim+complete -> IDLE.
REQ-037 SHALL cover illegal claim/complete: claim ID 0, claim ID 49, complete of a PEND source -> no state change anywhere.
REQ-038 SHALL cover a same-cycle claim of ID 5 and completion of ID 7 (ID 7 in BUSY) -> both applied in that cycle.
REQ-039 SHALL cover disabling while pending and while busy: clearing en in PEND -> IDLE; clearing en in BUSY -> stays BUSY until complete, then IDLE.
REQ-040 SHALL cover reset asserted while 10 sources are BUSY -> all outputs 0 immediately (asynchronously), with no re-pend before SYNC_STAGES+1 cycles after release.
